tiny_soc_stop_monitor: RTL



---
 rtl/tiny_soc_stop_monitor.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/tiny_soc_stop_monitor.sv
// tiny_soc_stop_monitor
// Passive observer on the tiny SoC data-memory request bus. It never drives
// or stalls the bus. It watches write transactions in parallel with the data
// SRAM and provides three services:
//   - End-of-test detection: a write to the stop mailbox latches a stop code
//     and freezes the run.
//   - Signature capture: writes to the signature port are queued in a small
//     first-word-fall-through FIFO for the harness to drain.
//   - Cycle accounting: counts cycles while running and flags a timeout.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   data_mem_req_i/gnt_i/we_i      request handshake and write enable
//   data_mem_addr_i                byte address (bits [2:0] ignored for matching)
//   data_mem_wdata_i, _strb_i      write data and byte strobes
//   sig_ready_i                    consumer accepts the FIFO head word
//   sig_valid_o, sig_data_o        FIFO non-empty flag and head word
//   sig_overflow_o                 sticky: a signature write was dropped
//   stop_o, stop_code_o            sticky stop flag and captured stop code
//   timeout_o                      sticky timeout flag
//   cycle_count_o                  cycles spent in RUN (saturating)
module tiny_soc_stop_monitor #(
    parameter logic [31:0] StopAddr      = 32'h8000_1000,
    parameter logic [31:0] SigAddr       = 32'h8000_1008,
    parameter int unsigned SigFifoDepth  = 8,
    parameter logic [31:0] TimeoutCycles = 32'd1000000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_mem_req_i,
    input  logic        data_mem_gnt_i,
    input  logic        data_mem_we_i,
    input  logic [31:0] data_mem_addr_i,
    input  logic [63:0] data_mem_wdata_i,
    input  logic [7:0]  data_mem_strb_i,
    input  logic        sig_ready_i,
    output logic        sig_valid_o,
    output logic [63:0] sig_data_o,
    output logic        sig_overflow_o,
    output logic        stop_o,
    output logic [31:0] stop_code_o,
    output logic        timeout_o,
    output logic [31:0] cycle_count_o
);

    localparam int unsigned PtrW = $clog2(SigFifoDepth);
    localparam logic [PtrW-1:0] PtrOne   = {{(PtrW-1){1'b0}}, 1'b1};
    localparam logic [PtrW:0]   CntOne   = {{PtrW{1'b0}}, 1'b1};
    localparam logic [PtrW:0]   CntFull  = (PtrW+1)'(SigFifoDepth);
    localparam logic [31:0]     TmoLast  = TimeoutCycles - 32'd1;

    // RUN is encoded as zero so the reset value lands there.
    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_STOPPED   = 2'd1,
        ST_TIMED_OUT = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [31:0]    count_q, count_d;
    logic [31:0]    code_q, code_d;
    logic           stop_q, stop_d;
    logic           timeout_q, timeout_d;

    logic [63:0]    mem_q [SigFifoDepth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]  fcnt_q, fcnt_d;
    logic           valid_q, valid_d;
    logic           ovf_q, ovf_d;

    logic           wr_fire_s;
    logic           stop_hit_s;
    logic           sig_hit_s;
    logic           full_s;
    logic           pop_s;
    logic           push_ok_s;
    logic           unused_s;

    // Bus decode: only granted writes count, and only the 8-byte word address matters.
    assign wr_fire_s  = data_mem_req_i & data_mem_gnt_i & data_mem_we_i;
    assign stop_hit_s = wr_fire_s & (data_mem_addr_i[31:3] == StopAddr[31:3])
                        & (data_mem_strb_i[3:0] != 4'b0000);
    assign sig_hit_s  = wr_fire_s & (data_mem_addr_i[31:3] == SigAddr[31:3]);
    assign unused_s   = ^{data_mem_addr_i[2:0], data_mem_strb_i[7:4]};

    // A full FIFO still accepts a push when the head is popped in the same cycle.
    assign full_s    = (fcnt_q == CntFull);
    assign pop_s     = valid_q & sig_ready_i;
    assign push_ok_s = sig_hit_s & (~full_s | pop_s);

    // Run-control FSM: stop has priority over a coinciding timeout.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        code_d    = code_q;
        stop_d    = stop_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_RUN: begin
                if (count_q != 32'hFFFF_FFFF) begin
                    count_d = count_q + 32'd1;
                end else begin
                    count_d = count_q;
                end
                if (stop_hit_s) begin
                    state_d = ST_STOPPED;
                    stop_d  = 1'b1;
                    code_d  = data_mem_wdata_i[31:0];
                end else if (count_q == TmoLast) begin
                    state_d   = ST_TIMED_OUT;
                    timeout_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STOPPED:   state_d = ST_STOPPED;
            ST_TIMED_OUT: state_d = ST_TIMED_OUT;
            default: begin
                // Unreachable encoding: park as timed out so the harness sees a failure.
                state_d   = ST_TIMED_OUT;
                timeout_d = 1'b1;
            end
        endcase
    end

    // FIFO bookkeeping: pointers wrap naturally at the power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fcnt_d   = fcnt_q;
        ovf_d    = ovf_q | (sig_hit_s & full_s & ~pop_s);
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_s})
            2'b10:   fcnt_d = fcnt_q + CntOne;
            2'b01:   fcnt_d = fcnt_q - CntOne;
            default: fcnt_d = fcnt_q;
        endcase
        valid_d = (fcnt_d != {(PtrW+1){1'b0}});
    end

    // State, flags, counter and FIFO control registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_RUN;
            count_q   <= 32'd0;
            code_q    <= 32'd0;
            stop_q    <= 1'b0;
            timeout_q <= 1'b0;
            wr_ptr_q  <= {PtrW{1'b0}};
            rd_ptr_q  <= {PtrW{1'b0}};
            fcnt_q    <= {(PtrW+1){1'b0}};
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            code_q    <= code_d;
            stop_q    <= stop_d;
            timeout_q <= timeout_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fcnt_q    <= fcnt_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
        end
    end

    // FIFO storage; contents are only meaningful under the valid count, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= data_mem_wdata_i;
        end
    end

    // Head word is forced to zero when empty so every output reads 0 out of reset.
    always_comb begin
        if (valid_q) begin
            sig_data_o = mem_q[rd_ptr_q];
        end else begin
            sig_data_o = 64'd0;
        end
    end

    assign sig_valid_o    = valid_q;
    assign sig_overflow_o = ovf_q;
    assign stop_o         = stop_q;
    assign stop_code_o    = code_q;
    assign timeout_o      = timeout_q;
    assign cycle_count_o  = count_q;

endmodule
